// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: op codes, FSM encoding,
// byte-count and load-extension helpers.
package mem_lsu_pkg;

    localparam int XLEN    = 32;
    localparam int BYTE_W  = 8;
    localparam int ALUOP_W = 8;
    localparam int REG_W   = 5;

    typedef logic [ALUOP_W-1:0] alu_op_t;
    typedef logic [REG_W-1:0]   reg_addr_t;

    localparam alu_op_t EX_NOP_OP = 8'h00;
    localparam alu_op_t EX_ADD_OP = 8'h01;
    localparam alu_op_t EX_LB_OP  = 8'h10;
    localparam alu_op_t EX_LH_OP  = 8'h11;
    localparam alu_op_t EX_LW_OP  = 8'h12;
    localparam alu_op_t EX_LBU_OP = 8'h13;
    localparam alu_op_t EX_LHU_OP = 8'h14;
    localparam alu_op_t EX_SB_OP  = 8'h18;
    localparam alu_op_t EX_SH_OP  = 8'h19;
    localparam alu_op_t EX_SW_OP  = 8'h1A;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_XFER,
        LSU_DONE
    } lsu_state_t;

    // Zero means the op does not touch memory.
    function automatic logic [2:0] byte_count(input alu_op_t op);
        case (op)
            EX_LB_OP, EX_LBU_OP, EX_SB_OP: byte_count = 3'd1;
            EX_LH_OP, EX_LHU_OP, EX_SH_OP: byte_count = 3'd2;
            EX_LW_OP, EX_SW_OP:            byte_count = 3'd4;
            default:                       byte_count = 3'd0;
        endcase
    endfunction

    function automatic logic is_store_op(input alu_op_t op);
        return (op == EX_SB_OP) || (op == EX_SH_OP) || (op == EX_SW_OP);
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input alu_op_t op, input logic [XLEN-1:0] raw);
        case (op)
            EX_LB_OP:  load_extend = {{(XLEN-8){raw[7]}}, raw[7:0]};
            EX_LH_OP:  load_extend = {{(XLEN-16){raw[15]}}, raw[15:0]};
            EX_LBU_OP: load_extend = {{(XLEN-8){1'b0}}, raw[7:0]};
            EX_LHU_OP: load_extend = {{(XLEN-16){1'b0}}, raw[15:0]};
            default:   load_extend = raw;
        endcase
    endfunction

endpackage

// File: rtl/lsu_byte_seq.sv
// Byte sequencer: walks k = 0..N-1 over the 8-bit memory port, holding
// address/data stable until each byte is acknowledged.
module lsu_byte_seq
    import mem_lsu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              active,
    input  logic              store,
    input  logic [2:0]        n_bytes,
    input  logic [XLEN-1:0]   base_addr,
    input  logic [XLEN-1:0]   st_data,
    input  logic              mem_ack_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [BYTE_W-1:0] mem_wdata_o,
    output logic              byte_ack,
    output logic              last_ack,
    output logic [1:0]        byte_idx
);

    logic [1:0] k;

    always_ff @(posedge clk) begin
        if (!rst) begin
            k <= '0;
        end else if (start) begin
            k <= '0;
        end else if (byte_ack) begin
            k <= k + 2'd1;
        end
    end

    // An ack with no request outstanding never advances the counter.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        byte_ack    = 1'b0;
        last_ack    = 1'b0;
        if (active) begin
            mem_req_o   = 1'b1;
            mem_we_o    = store;
            mem_addr_o  = base_addr + {{(XLEN-2){1'b0}}, k};
            mem_wdata_o = st_data[{k, 3'b000} +: BYTE_W];
            byte_ack    = mem_ack_i;
            last_ack    = mem_ack_i && ({1'b0, k} == (n_bytes - 3'd1));
        end
    end

    assign byte_idx = k;

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: FSM, captured request, little-endian load assembly
// and the writeback mux; byte traffic is delegated to lsu_byte_seq.
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  alu_op_t           aluop_i,
    input  logic [XLEN-1:0]   mem_addr_i,
    input  logic [XLEN-1:0]   st_data_i,
    input  logic              w_enable_i,
    input  reg_addr_t         w_addr_i,
    input  logic [XLEN-1:0]   w_data_i,
    output logic              w_enable_o,
    output reg_addr_t         w_addr_o,
    output logic [XLEN-1:0]   w_data_o,
    output logic              stall_req_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [BYTE_W-1:0] mem_wdata_o,
    input  logic [BYTE_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    lsu_state_t      state, next_state;
    alu_op_t         op_q;
    logic [XLEN-1:0] addr_q, st_data_q, load_buf;
    reg_addr_t       w_addr_q;
    logic            start, byte_ack, last_ack;
    logic [1:0]      byte_idx;

    assign start = (state == LSU_IDLE) && valid_i && (byte_count(aluop_i) != 3'd0);

    // After capture the unit works only from its own copies of the request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= LSU_IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            st_data_q <= '0;
            w_addr_q  <= '0;
            load_buf  <= '0;
        end else begin
            state <= next_state;
            if (start) begin
                op_q      <= aluop_i;
                addr_q    <= mem_addr_i;
                st_data_q <= st_data_i;
                w_addr_q  <= w_addr_i;
                load_buf  <= '0;
            end else if (byte_ack && !is_store_op(op_q)) begin
                load_buf[{byte_idx, 3'b000} +: BYTE_W] <= mem_rdata_i;
            end
        end
    end

    lsu_byte_seq u_seq (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .active      (state == LSU_XFER),
        .store       (is_store_op(op_q)),
        .n_bytes     (byte_count(op_q)),
        .base_addr   (addr_q),
        .st_data     (st_data_q),
        .mem_ack_i   (mem_ack_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .byte_ack    (byte_ack),
        .last_ack    (last_ack),
        .byte_idx    (byte_idx)
    );

    // Writes to x0 are suppressed in every state.
    always_comb begin
        next_state  = state;
        stall_req_o = 1'b0;
        w_enable_o  = 1'b0;
        w_addr_o    = '0;
        w_data_o    = '0;
        case (state)
            LSU_IDLE: begin
                if (valid_i) begin
                    if (byte_count(aluop_i) != 3'd0) begin
                        stall_req_o = 1'b1;
                        next_state  = LSU_XFER;
                    end else begin
                        w_enable_o = w_enable_i && (w_addr_i != '0);
                        w_addr_o   = w_addr_i;
                        w_data_o   = w_data_i;
                    end
                end
            end
            LSU_XFER: begin
                stall_req_o = 1'b1;
                if (last_ack) begin
                    next_state = LSU_DONE;
                end
            end
            LSU_DONE: begin
                next_state = LSU_IDLE;
                if (!is_store_op(op_q)) begin
                    w_enable_o = (w_addr_q != '0);
                    w_addr_o   = w_addr_q;
                    w_data_o   = load_extend(op_q, load_buf);
                end
            end
            default: next_state = LSU_IDLE;
        endcase
    end

endmodule
